// File: rtl/eudp_pkg.sv
// eudp_pkg: opcode and FSM state types plus default parameters shared by
// eudp_gen2 and its register file.
package eudp_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_NUM_REGS    = 4;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_MEM_TIMEOUT = 16;
  localparam int unsigned OP_W            = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'h0,
    OP_MOV    = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_NOT    = 4'h7,
    OP_SHL    = 4'h8,
    OP_SHR    = 4'h9,
    OP_CMP_EQ = 4'hA,
    OP_CMP_LT = 4'hB,
    OP_LOAD   = 4'hC,
    OP_STORE  = 4'hD,
    OP_RSV_E  = 4'hE,
    OP_RSV_F  = 4'hF
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

  // Opcodes that write rd from the ALU and refresh the zero flag.
  function automatic logic op_writes_rd(op_e op);
    return op inside {[OP_MOV:OP_SHR]};
  endfunction

  function automatic logic op_is_mem(op_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/eudp_regfile.sv
// eudp_regfile: NUM_REGS x DATA_W register file with two asynchronous read
// ports and one synchronous write port; reads return the pre-write value.
module eudp_regfile
  import eudp_pkg::*;
#(
  parameter int unsigned  DATA_W   = DEF_DATA_W,
  parameter int unsigned  NUM_REGS = DEF_NUM_REGS,
  localparam int unsigned RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RSEL_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [RSEL_W-1:0] ra0_i,
  input  logic [RSEL_W-1:0] ra1_i,
  output logic [DATA_W-1:0] rdata0_c_o,
  output logic [DATA_W-1:0] rdata1_c_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rdata0_c_o = regs_q[ra0_i];
  assign rdata1_c_o = regs_q[ra1_i];

endmodule

// File: rtl/eudp_gen2.sv
// eudp_gen2: register file, single-cycle ALU with flags, and req/ack data port.
// Define EUDP_MEM_TIMEOUT_EN to abort memory requests after MEM_TIMEOUT cycles.
module eudp_gen2
  import eudp_pkg::*;
#(
  parameter int unsigned  DATA_W      = DEF_DATA_W,
  parameter int unsigned  NUM_REGS    = DEF_NUM_REGS,
  parameter int unsigned  ADDR_W      = DEF_ADDR_W,
  parameter int unsigned  MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  localparam int unsigned RSEL_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [OP_W-1:0]   op_code_i,
  input  logic [RSEL_W-1:0] rd_sel_i,
  input  logic [RSEL_W-1:0] rs0_sel_i,
  input  logic [RSEL_W-1:0] rs1_sel_i,
  input  logic              imm_sel_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_ack_i,
  output logic              cmp_flag_o,
  output logic              carry_flag_o,
  output logic              zero_flag_o,
  output logic              err_o
);

  op_e               op_c;
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [RSEL_W-1:0] mem_rd_q, mem_rd_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              cmp_q, cmp_d;
  logic              err_q, err_d;

  logic [RSEL_W-1:0] ra0_c;
  logic [DATA_W-1:0] rdata0_c, rdata1_c, op1_c;
  logic              rf_we_c;
  logic [RSEL_W-1:0] rf_wa_c;
  logic [DATA_W-1:0] rf_wd_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              alu_cy_c;
  logic              tmo_c;

  assign op_c  = op_e'(op_code_i);
  // Memory ops never use op0, so port 0 doubles as the store-data read port.
  assign ra0_c = op_is_mem(op_c) ? rd_sel_i : rs0_sel_i;
  assign op1_c = imm_sel_i ? imm_i : rdata1_c;

  eudp_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst),
    .we_i       (rf_we_c),
    .wa_i       (rf_wa_c),
    .wd_i       (rf_wd_c),
    .ra0_i      (ra0_c),
    .ra1_i      (rs1_sel_i),
    .rdata0_c_o (rdata0_c),
    .rdata1_c_o (rdata1_c)
  );

  // Single-cycle ALU; carry defaults to its held value for non-carry ops.
  always_comb begin
    alu_res_c = '0;
    alu_cy_c  = carry_q;
    case (op_c)
      OP_MOV: alu_res_c = op1_c;
      OP_ADD: {alu_cy_c, alu_res_c} = {1'b0, rdata0_c} + {1'b0, op1_c};
      OP_SUB: begin
        alu_res_c = rdata0_c - op1_c;
        alu_cy_c  = (rdata0_c < op1_c);
      end
      OP_AND: alu_res_c = rdata0_c & op1_c;
      OP_OR:  alu_res_c = rdata0_c | op1_c;
      OP_XOR: alu_res_c = rdata0_c ^ op1_c;
      OP_NOT: alu_res_c = ~rdata0_c;
      OP_SHL: begin
        alu_res_c = {rdata0_c[DATA_W-2:0], 1'b0};
        alu_cy_c  = rdata0_c[DATA_W-1];
      end
      OP_SHR: begin
        alu_res_c = {1'b0, rdata0_c[DATA_W-1:1]};
        alu_cy_c  = rdata0_c[0];
      end
      default: ;
    endcase
  end

`ifdef EUDP_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts completed MEM cycles; cleared whenever the FSM is idle.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_MEM) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  assign tmo_c = (state_q == ST_MEM) && !mem_ack_i &&
                 (tmo_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_c;

  assign tmo_c            = 1'b0;
  assign unused_timeout_c = (MEM_TIMEOUT != 0);
`endif

  // Next-state, register-file write and flag/memory-port updates.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_d      = mem_rd_q;
    carry_d       = carry_q;
    zero_d        = zero_q;
    cmp_d         = cmp_q;
    err_d         = 1'b0;
    rf_we_c       = 1'b0;
    rf_wa_c       = rd_sel_i;
    rf_wd_c       = alu_res_c;

    case (state_q)
      ST_IDLE: begin
        if (op_valid_i) begin
          if (op_writes_rd(op_c)) begin
            rf_we_c = 1'b1;
            zero_d  = (alu_res_c == '0);
            carry_d = alu_cy_c;
          end
          if (op_c == OP_CMP_EQ) cmp_d = (rdata0_c == op1_c);
          if (op_c == OP_CMP_LT) cmp_d = (rdata0_c < op1_c);
          if (op_is_mem(op_c)) begin
            state_d       = ST_MEM;
            mem_req_d     = 1'b1;
            mem_we_d      = (op_c == OP_STORE);
            mem_addr_d    = op1_c[ADDR_W-1:0];
            mem_wr_data_d = rdata0_c;
            mem_rd_d      = rd_sel_i;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack_i) begin
          rf_we_c   = !mem_we_q;
          rf_wa_c   = mem_rd_q;
          rf_wd_c   = mem_rd_data_i;
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else if (tmo_c) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_q      <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      cmp_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_q      <= mem_rd_d;
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      cmp_q         <= cmp_d;
      err_q         <= err_d;
    end
  end

  assign op_ready_o    = (state_q == ST_IDLE);
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign cmp_flag_o    = cmp_q;
  assign carry_flag_o  = carry_q;
  assign zero_flag_o   = zero_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_eudp_gen2.sv
// tb_eudp_gen2: randomized and directed checks of eudp_gen2 against an
// arithmetic reference model of the register file and flags.
module tb_eudp_gen2;

  localparam int unsigned DW   = 8;
  localparam int unsigned NR   = 4;
  localparam int unsigned RW   = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned TO   = 4;
  localparam int          MAXV = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid_i, op_ready_o;
  logic [3:0]    op_code_i;
  logic [RW-1:0] rd_sel_i, rs0_sel_i, rs1_sel_i;
  logic          imm_sel_i;
  logic [DW-1:0] imm_i;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wr_data_o, mem_rd_data_i;
  logic          mem_ack_i;
  logic          cmp_flag_o, carry_flag_o, zero_flag_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  int m_reg [NR];
  bit m_cy, m_z, m_cmp;

  eudp_gen2 #(
    .DATA_W      (DW),
    .NUM_REGS    (NR),
    .ADDR_W      (AW),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .op_code_i     (op_code_i),
    .rd_sel_i      (rd_sel_i),
    .rs0_sel_i     (rs0_sel_i),
    .rs1_sel_i     (rs1_sel_i),
    .imm_sel_i     (imm_sel_i),
    .imm_i         (imm_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_data_i (mem_rd_data_i),
    .mem_ack_i     (mem_ack_i),
    .cmp_flag_o    (cmp_flag_o),
    .carry_flag_o  (carry_flag_o),
    .zero_flag_o   (zero_flag_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  // Reference model: one ALU/CMP operation computed with plain integer arithmetic.
  task automatic model_exec(input int op, input int rd, input int rs0, input int rs1,
                            input int isel, input int imm);
    int a, b, r;
    bit wr;
    a  = m_reg[rs0];
    b  = (isel != 0) ? imm : m_reg[rs1];
    r  = 0;
    wr = 1'b1;
    case (op)
      1:  r = b;
      2:  begin r = (a + b) % MAXV; m_cy = ((a + b) >= MAXV); end
      3:  begin r = (a - b + MAXV) % MAXV; m_cy = (a < b); end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = MAXV - 1 - a;
      8:  begin r = (a * 2) % MAXV; m_cy = (a >= MAXV / 2); end
      9:  begin r = a / 2; m_cy = (a % 2 == 1); end
      10: begin m_cmp = (a == b); wr = 1'b0; end
      11: begin m_cmp = (a < b); wr = 1'b0; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_reg[rd] = r;
      m_z       = (r == 0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) m_reg[i] = 0;
    m_cy  = 1'b0;
    m_z   = 1'b0;
    m_cmp = 1'b0;
  endtask

  task automatic drive(input int op, input int rd, input int rs0, input int rs1,
                       input int isel, input int imm);
    op_valid_i = 1'b1;
    op_code_i  = 4'(op);
    rd_sel_i   = RW'(rd);
    rs0_sel_i  = RW'(rs0);
    rs1_sel_i  = RW'(rs1);
    imm_sel_i  = (isel != 0);
    imm_i      = DW'(imm);
  endtask

  // One-cycle op issued in IDLE; returns the flags {carry, zero, cmp} after the edge.
  task automatic do_op(input int op, input int rd, input int rs0, input int rs1,
                       input int isel, input int imm, output logic [2:0] flags);
    @(negedge clk);
    drive(op, rd, rs0, rs1, isel, imm);
    model_exec(op, rd, rs0, rs1, isel, imm);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    flags = {carry_flag_o, zero_flag_o, cmp_flag_o};
  endtask

  // Observes a register through a STORE with an immediate one-cycle ack.
  task automatic read_reg(input int r, output logic [DW-1:0] val);
    @(negedge clk);
    drive(13, r, 0, 0, 1, 'h55);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    val = mem_wr_data_o;
    @(negedge clk);
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    op_valid_i = 1'b0; op_code_i = '0; rd_sel_i = '0; rs0_sel_i = '0; rs1_sel_i = '0;
    imm_sel_i = 1'b0; imm_i = '0; mem_ack_i = 1'b0; mem_rd_data_i = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({op_ready_o, mem_req_o, mem_we_o, err_o, carry_flag_o, zero_flag_o, cmp_flag_o} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy/req/we/err/cy/z/cmp=%b expected 1000000",
               {op_ready_o, mem_req_o, mem_we_o, err_o, carry_flag_o, zero_flag_o, cmp_flag_o});
    end
    n_tests++;
    if ({mem_addr_o, mem_wr_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%h wdata=%h expected 0", mem_addr_o, mem_wr_data_o);
    end
    rst = 1'b1;
    for (int r = 0; r < int'(NR); r++) begin
      read_reg(r, v);
      n_tests++;
      if (v !== '0) begin
        n_fail++;
        $display("FAIL reset_reg R%0d got %h expected 00", r, v);
      end
    end
  endtask

  task automatic test_alu_directed();
    logic [2:0] f;
    logic [DW-1:0] v;
    do_op(1, 1, 0, 0, 1, 'hF0, f);
    do_op(1, 2, 0, 0, 1, 'h20, f);
    do_op(2, 3, 1, 2, 0, 0, f);
    n_tests++;
    if (f !== 3'b100) begin n_fail++; $display("FAIL add_flags got %b expected 100", f); end
    read_reg(3, v);
    n_tests++;
    if (v !== 8'h10) begin n_fail++; $display("FAIL add_result got %h expected 10", v); end
    do_op(1, 0, 0, 0, 1, 'h05, f);
    do_op(1, 1, 0, 0, 1, 'h07, f);
    do_op(3, 0, 0, 1, 0, 0, f);
    n_tests++;
    if (f[2] !== 1'b1) begin n_fail++; $display("FAIL sub_borrow got %b expected 1", f[2]); end
    do_op(1, 2, 0, 0, 1, 'h05, f);
    do_op(11, 0, 2, 1, 0, 0, f);
    n_tests++;
    if (f[0] !== 1'b1) begin n_fail++; $display("FAIL cmp_lt got %b expected 1", f[0]); end
    do_op(10, 0, 0, 0, 1, 'hFD, f);
    n_tests++;
    if (f[0] !== 1'b0) begin n_fail++; $display("FAIL cmp_eq_ne got %b expected 0", f[0]); end
    do_op(10, 0, 0, 0, 1, 'hFE, f);
    n_tests++;
    if (f[0] !== 1'b1) begin n_fail++; $display("FAIL cmp_eq got %b expected 1", f[0]); end
    read_reg(0, v);
    n_tests++;
    if (v !== 8'hFE) begin n_fail++; $display("FAIL sub_result got %h expected fe", v); end
    do_op(6, 1, 1, 1, 0, 0, f);
    n_tests++;
    if (f !== 3'b111) begin n_fail++; $display("FAIL xor_zero got %b expected 111", f); end
  endtask

  task automatic test_random_alu();
    logic [2:0] f;
    logic [DW-1:0] v;
    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(13, 0));
      if (op == 12) op = 14;
      else if (op == 13) op = 15;
      do_op(op, int'($urandom_range(NR - 1, 0)), int'($urandom_range(NR - 1, 0)),
            int'($urandom_range(NR - 1, 0)), int'($urandom_range(1, 0)),
            ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(MAXV - 1, 0)), f);
      n_tests++;
      if (f !== {m_cy, m_z, m_cmp}) begin
        n_fail++;
        $display("FAIL rand_flags i=%0d op=%0d got %b expected %b", i, op, f, {m_cy, m_z, m_cmp});
      end
      if (i % 50 == 49) begin
        for (int r = 0; r < int'(NR); r++) begin
          read_reg(r, v);
          n_tests++;
          if (v !== DW'(m_reg[r])) begin
            n_fail++;
            $display("FAIL rand_reg R%0d got %h expected %h", r, v, DW'(m_reg[r]));
          end
        end
      end
    end
  endtask

  task automatic test_load();
    logic [DW-1:0] v;
    // Ack while idle must be ignored.
    @(negedge clk);
    mem_ack_i = 1'b1; mem_rd_data_i = 8'hEE;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    drive(12, 2, 0, 0, 1, 'h3C);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({mem_req_o, op_ready_o, mem_we_o, mem_addr_o} !== {3'b100, 8'h3C}) begin
        n_fail++;
        $display("FAIL load_wait c%0d got req/rdy/we=%b addr=%h expected 100 3c",
                 i, {mem_req_o, op_ready_o, mem_we_o}, mem_addr_o);
      end
      @(negedge clk);
      if (i == 2) begin mem_ack_i = 1'b1; mem_rd_data_i = 8'hA5; end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    m_reg[2] = 'hA5;
    n_tests++;
    if ({mem_req_o, op_ready_o, err_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL load_done got req/rdy/err=%b expected 010", {mem_req_o, op_ready_o, err_o});
    end
    for (int n = 0; n < 6; n++) begin
      int rd, lat, dat;
      rd  = int'($urandom_range(NR - 1, 0));
      lat = int'($urandom_range(3, 1));
      dat = int'($urandom_range(MAXV - 1, 0));
      @(negedge clk);
      drive(12, rd, 0, 0, 1, int'($urandom_range(MAXV - 1, 0)));
      @(posedge clk); #1;
      op_valid_i = 1'b0;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (i == lat - 1) begin mem_ack_i = 1'b1; mem_rd_data_i = DW'(dat); end
        @(posedge clk); #1;
      end
      mem_ack_i = 1'b0;
      m_reg[rd] = dat;
    end
    for (int r = 0; r < int'(NR); r++) begin
      read_reg(r, v);
      n_tests++;
      if (v !== DW'(m_reg[r])) begin
        n_fail++;
        $display("FAIL load_reg R%0d got %h expected %h", r, v, DW'(m_reg[r]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f;
    logic [DW-1:0] v;
    do_op(1, 2, 0, 0, 1, 'h07, f);
    do_op(1, 1, 0, 0, 1, 'h10, f);
    do_op(1, 3, 0, 0, 1, 'h5A, f);
    @(negedge clk);
    drive(13, 3, 0, 0, 1, 'h80);
    @(posedge clk); #1;
    drive(2, 1, 1, 2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({mem_req_o, op_ready_o, mem_we_o, mem_addr_o, mem_wr_data_o} !== {3'b101, 8'h80, 8'h5A}) begin
        n_fail++;
        $display("FAIL store_hold c%0d got req/rdy/we=%b addr=%h data=%h expected 101 80 5a",
                 i, {mem_req_o, op_ready_o, mem_we_o}, mem_addr_o, mem_wr_data_o);
      end
      @(negedge clk);
      if (i == 1) mem_ack_i = 1'b1;
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    n_tests++;
    if ({mem_req_o, op_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL store_done got req/rdy=%b expected 01", {mem_req_o, op_ready_o});
    end
    model_exec(2, 1, 1, 2, 0, 0);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    n_tests++;
    if ({carry_flag_o, zero_flag_o, cmp_flag_o} !== {m_cy, m_z, m_cmp}) begin
      n_fail++;
      $display("FAIL b2b_flags got %b expected %b",
               {carry_flag_o, zero_flag_o, cmp_flag_o}, {m_cy, m_z, m_cmp});
    end
    read_reg(1, v);
    n_tests++;
    if (v !== 8'h17) begin n_fail++; $display("FAIL b2b_add got %h expected 17", v); end
  endtask

  task automatic test_reset_mid_mem();
    logic [2:0] f;
    logic [DW-1:0] v;
    @(negedge clk);
    drive(12, 1, 0, 0, 1, 'h10);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({mem_req_o, op_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_async got req/rdy=%b expected 01", {mem_req_o, op_ready_o});
    end
    @(negedge clk);
    mem_ack_i = 1'b1; mem_rd_data_i = 8'hC3;
    drive(1, 2, 0, 0, 1, 'h99);
    @(posedge clk); #1;
    @(negedge clk);
    mem_ack_i = 1'b0; op_valid_i = 1'b0; rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({carry_flag_o, zero_flag_o, cmp_flag_o, err_o, mem_req_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags got cy/z/cmp/err/req=%b expected 00000",
               {carry_flag_o, zero_flag_o, cmp_flag_o, err_o, mem_req_o});
    end
    for (int r = 0; r < int'(NR); r++) begin
      read_reg(r, v);
      n_tests++;
      if (v !== '0) begin n_fail++; $display("FAIL rst_reg R%0d got %h expected 00", r, v); end
    end
    do_op(1, 1, 0, 0, 1, 'h33, f);
    read_reg(1, v);
    n_tests++;
    if (v !== 8'h33) begin n_fail++; $display("FAIL rst_resume got %h expected 33", v); end
  endtask

`ifdef EUDP_MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] f;
    logic [DW-1:0] v;
    int req_cnt, err_cnt;
    do_op(1, 3, 0, 0, 1, 'h66, f);
    @(negedge clk);
    drive(12, 3, 0, 0, 1, 'h44);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    req_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req_o) req_cnt++;
      if (err_o) err_cnt++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (req_cnt != int'(TO) || err_cnt != 1 || op_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout got req_cycles=%0d err_cycles=%0d rdy=%b expected %0d 1 1",
               req_cnt, err_cnt, op_ready_o, TO);
    end
    read_reg(3, v);
    n_tests++;
    if (v !== 8'h66) begin n_fail++; $display("FAIL timeout_nowrite got %h expected 66", v); end
    @(negedge clk);
    drive(12, 3, 0, 0, 1, 'h45);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    err_cnt = 0;
    for (int i = 0; i < int'(TO); i++) begin
      if (err_o) err_cnt++;
      @(negedge clk);
      if (i == int'(TO) - 1) begin mem_ack_i = 1'b1; mem_rd_data_i = 8'h9C; end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    if (err_o) err_cnt++;
    @(posedge clk); #1;
    if (err_o) err_cnt++;
    n_tests++;
    if (err_cnt != 0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL last_cycle_ack got err_cycles=%0d req=%b expected 0 0", err_cnt, mem_req_o);
    end
    read_reg(3, v);
    n_tests++;
    if (v !== 8'h9C) begin n_fail++; $display("FAIL last_cycle_data got %h expected 9c", v); end
  endtask
`else
  task automatic test_long_wait();
    logic [DW-1:0] v;
    int req_cnt, err_cnt;
    @(negedge clk);
    drive(12, 0, 0, 0, 1, 'h21);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    req_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) req_cnt++;
      if (err_o) err_cnt++;
      @(negedge clk);
      if (i == 19) begin mem_ack_i = 1'b1; mem_rd_data_i = 8'h4B; end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    n_tests++;
    if (req_cnt != 20 || err_cnt != 0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL long_wait got req_cycles=%0d err_cycles=%0d req=%b expected 20 0 0",
               req_cnt, err_cnt, mem_req_o);
    end
    read_reg(0, v);
    n_tests++;
    if (v !== 8'h4B) begin n_fail++; $display("FAIL long_wait_data got %h expected 4b", v); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_directed();
    test_random_alu();
    test_load();
    test_back_to_back();
    test_reset_mid_mem();
`ifdef EUDP_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
